// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative radix-2 multiply/divide unit for the EX stage; stalls the front end while busy.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module ex_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_0,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, acc_step, acc_fix, prod_fix;
    logic [WIDTH-1:0]   opnd;      // multiplicand (mul) or divisor (div) magnitude
    logic               is_div, sign_q, sign_r;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               last_step, early_start, early_run;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem, fix_hi, fix_lo;

    assign mag_a = (md_op[0] && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign mag_b = (md_op[0] && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // acc = {hi, lo}: mul shifts right with the multiplier in lo; div shifts left with the quotient in lo
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd & {WIDTH{acc[0]}}};
        div_sh  = {acc, 1'b0};
        div_ge  = div_sh[2*WIDTH:WIDTH] >= {1'b0, opnd};
        div_rem = div_sh[2*WIDTH-1:WIDTH] - opnd;
        if (!is_div)
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        else if (div_ge)
            acc_step = {div_rem, acc[WIDTH-2:0], 1'b1};
        else
            acc_step = div_sh[2*WIDTH-1:0];
    end

    assign last_step = (cnt == CNT_W'(WIDTH-1));

`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0] rem_mask;
    // low bits of lo still hold unconsumed multiplier bits; the product sits above them
    assign rem_mask    = {WIDTH{1'b1}} >> (cnt + 1'b1);
    assign early_run   = !is_div && ((acc_step[WIDTH-1:0] & rem_mask) == '0);
    assign early_start = !md_op[1] && (mag_b == '0);
    assign acc_fix     = acc >> (WIDTH - int'(cnt));
`else
    assign early_run   = 1'b0;
    assign early_start = 1'b0;
    assign acc_fix     = acc;
`endif

    always_comb begin
        prod_fix = sign_q ? (~acc_fix + 1'b1) : acc_fix;
        fix_hi   = sign_r ? (~acc_fix[2*WIDTH-1:WIDTH] + 1'b1) : acc_fix[2*WIDTH-1:WIDTH];
        fix_lo   = (opnd == '0) ? '1 :
                   sign_q ? (~acc_fix[WIDTH-1:0] + 1'b1) : acc_fix[WIDTH-1:0];
        if (!is_div) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: if (start && !flush) begin
                stall     = 1'b1;
                state_nxt = early_start ? FIX : RUN;
            end
            RUN: begin
                busy  = 1'b1;
                stall = !flush;
                if (flush)                       state_nxt = IDLE;
                else if (last_step || early_run) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                stall     = !flush;
                state_nxt = flush ? IDLE : DONE;
            end
            DONE: begin
                done      = !flush;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            is_div    <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: if (start) begin
                    is_div <= md_op[1];
                    sign_q <= md_op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                    sign_r <= md_op[0] & a[WIDTH-1];
                    opnd   <= md_op[1] ? mag_b : mag_a;
                    acc    <= {{WIDTH{1'b0}}, (md_op[1] ? mag_a : mag_b)};
                    cnt    <= '0;
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    result_hi <= fix_hi;
                    result_lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: random ops against an arithmetic model plus fixed directed cases.
module tb_ex_muldiv;
    logic        clock = 1'b0;
    logic        reset_0 = 1'b0;
    logic        start = 1'b0, flush = 1'b0;
    logic [1:0]  md_op = 2'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, stall;
    logic [31:0] result_hi, result_lo;

    ex_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clock), .reset_0(reset_0), .start(start), .md_op(md_op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .stall(stall),
        .result_hi(result_hi), .result_lo(result_lo)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int nchecks = 0, nerrors = 0;
    int last_done = -1;

    // expected-behaviour state for the operation in flight
    logic        m_rst = 1'b1;
    logic        m_doneflag = 1'b0;
    int          m_s = 0, m_L = 0, m_end = 0, m_busy_end = 0;
    logic [31:0] m_old_hi = '0, m_old_lo = '0, m_new_hi = '0, m_new_lo = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        int     ix, iy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ix = $signed(x);
        iy = $signed(y);
        case (op)
            2'd0: return {32'd0, x} * {32'd0, y};
            2'd1: return 64'(sx * sy);
            2'd2: return (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
            default: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                return {32'(ix % iy), 32'(ix / iy)};
            end
        endcase
    endfunction

    // cycles from the start cycle to the done cycle
    function automatic int lat(input logic [1:0] op, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
        logic [31:0] m;
        int k;
        if (!op[1]) begin
            m = (op[0] && y[31]) ? (~y + 1) : y;
            k = 0;
            while (m != 0) begin k++; m = m >> 1; end
            return k + 2;
        end
`endif
        return 34;
    endfunction

    always @(negedge clock) begin
        logic        e_st, e_bz, e_dn;
        logic [31:0] e_hi, e_lo;
        if (m_rst) begin
            e_st = 0; e_bz = 0; e_dn = 0; e_hi = 0; e_lo = 0;
        end else begin
            e_st = (cyc >= m_s) && (cyc < m_end);
            e_bz = (cyc > m_s) && (cyc < m_busy_end);
            e_dn = m_doneflag && (cyc == m_s + m_L);
            if (m_doneflag && cyc >= m_s + m_L) begin e_hi = m_new_hi; e_lo = m_new_lo; end
            else begin e_hi = m_old_hi; e_lo = m_old_lo; end
        end
        chk("stall", stall, e_st);
        chk("busy", busy, e_bz);
        chk("done", done, e_dn);
        chk("result_hi", result_hi, e_hi);
        chk("result_lo", result_lo, e_lo);
        if (done === 1'b1) last_done = cyc;
    end

    task automatic launch(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y, input int hold);
        logic [63:0] r;
        int h;
        r = model(op, x, y);
        if (m_doneflag) begin m_old_hi = m_new_hi; m_old_lo = m_new_lo; end
        m_new_hi = r[63:32];
        m_new_lo = r[31:0];
        m_L = lat(op, y);
        m_s = cyc;
        m_end = cyc + m_L;
        m_busy_end = cyc + m_L;
        m_doneflag = 1'b1;
        h = (hold < m_L) ? hold : m_L - 1;
        start = 1'b1; md_op = op; a = x; b = y;
        for (int i = 1; i < h; i++) begin
            @(posedge clock); #1;
            a = $urandom; b = $urandom; md_op = 2'($urandom);
        end
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic finish_op();
        while (cyc <= m_s + m_L) begin @(posedge clock); #1; end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        launch(op, x, y, 1);
        finish_op();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: run did not complete within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  op;
        logic [31:0] x, y;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_lo", result_lo, 0);
        chk("reset_stall", stall, 0);
        reset_0 = 1'b1; m_rst = 1'b0;
        @(posedge clock); #1;

        run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_ff_hi", result_hi, 32'hFFFFFFFE);
        chk("multu_ff_lo", result_lo, 32'h00000001);
        chk("multu_ff_latency", last_done - m_s, 34);

        run_op(2'd1, 32'hFFFFFFFD, 32'd7);
        chk("mult_neg_hi", result_hi, 32'hFFFFFFFF);
        chk("mult_neg_lo", result_lo, 32'hFFFFFFEB);

        run_op(2'd3, 32'hFFFFFFF9, 32'd2);
        chk("div_neg_q", result_lo, 32'hFFFFFFFD);
        chk("div_neg_r", result_hi, 32'hFFFFFFFF);

        run_op(2'd2, 32'd100, 32'd0);
        chk("divu_zero_q", result_lo, 32'hFFFFFFFF);
        chk("divu_zero_r", result_hi, 32'd100);
        chk("divu_zero_latency", last_done - m_s, 34);

        run_op(2'd3, 32'h80000000, 32'hFFFFFFFF);
        chk("div_ovf_q", result_lo, 32'h80000000);
        chk("div_ovf_r", result_hi, 32'd0);

        // flush mid-RUN: no done, results keep the overflow case values
        launch(2'd2, 32'd1000, 32'd7, 1);
        while (cyc < m_s + 10) begin @(posedge clock); #1; end
        flush = 1'b1; m_end = cyc; m_busy_end = cyc + 1; m_doneflag = 1'b0;
        @(posedge clock); #1;
        flush = 1'b0;
        chk("flush_idle_busy", busy, 0);
        while (cyc < m_s + 40) begin @(posedge clock); #1; end
        chk("flush_no_done", last_done < m_s, 1);
        chk("flush_keep_lo", result_lo, 32'h80000000);
        chk("flush_keep_hi", result_hi, 32'd0);

        // flush wins over start in IDLE
        start = 1'b1; flush = 1'b1; md_op = 2'd0; a = 32'd3; b = 32'd3;
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_prio_busy", busy, 0);

        // start held through RUN with changing operands is ignored
        launch(2'd0, 32'd6, 32'd7, 8);
        finish_op();
        chk("held_lo", result_lo, 32'd42);
        chk("held_hi", result_hi, 32'd0);

        run_op(2'd0, 32'd5, 32'd3);
        chk("multu_small_lo", result_lo, 32'd15);
        chk("multu_small_hi", result_hi, 32'd0);
`ifdef MULDIV_EARLY_OUT_EN
        chk("multu_small_latency", last_done - m_s, 4);
`else
        chk("multu_small_latency", last_done - m_s, 34);
`endif

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = $urandom_range(1, 15);
                2: y = 32'hFFFFFFFF;
                default: y = $urandom;
            endcase
            run_op(op, x, y);
        end

        // reset mid-RUN returns everything to zero at once
        launch(2'd0, 32'h12345678, 32'hFFFFFFFF, 1);
        repeat (4) begin @(posedge clock); #1; end
        reset_0 = 1'b0; m_rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_hi", result_hi, 0);
        chk("rst_mid_lo", result_lo, 0);
        @(posedge clock); #1;
        reset_0 = 1'b1;
        m_old_hi = '0; m_old_lo = '0; m_new_hi = '0; m_new_lo = '0;
        m_doneflag = 1'b0; m_s = cyc; m_end = cyc; m_busy_end = cyc;
        m_rst = 1'b0;
        @(posedge clock); #1;

        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("post_rst_lo", result_lo, 32'd1);

        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
